// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the memory access unit: FSM states,
// the register-window address tag and the register-index width helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] REG_WINDOW_TAG = 4'hF;

  function automatic int reg_idx_w(input int threads, input int regs_per_thread);
    return $clog2(threads) + $clog2(regs_per_thread);
  endfunction

endpackage

// File: rtl/mem_access_regfile.sv
// Per-thread register window: THREADS x REGS_PER_THREAD words, cleared on reset,
// synchronous write and registered read addressed by {thread, word}.
module mem_access_regfile
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int THREADS         = 4,
  parameter int REGS_PER_THREAD = 8,
  localparam int IDX_W          = reg_idx_w(THREADS, REGS_PER_THREAD),
  localparam int DEPTH          = THREADS * REGS_PER_THREAD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_idx] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: register-window accesses served locally, all others over a
// req/ack system bus. Optional bus timeout compiled in with MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int THREADS         = 4,
  parameter int REGS_PER_THREAD = 8,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       f_enable,
  input  logic                       write_mode,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_i,
  input  logic [$clog2(THREADS)-1:0] thread,
  output logic [DATA_W-1:0]          data_o,
  output logic                       ack,
  output logic                       err,
  output logic                       busy,
  output logic [ADDR_W-1:0]          w_addr,
  output logic [DATA_W-1:0]          w_data_o,
  output logic                       w_write,
  output logic                       w_req,
  input  logic [DATA_W-1:0]          w_data_i,
  input  logic                       w_ack,
  input  logic                       w_err,
  output state_t                     o_state
);

  // Bus handshake: w_req is raised and held with w_addr/w_data_o/w_write
  // stable until the slave answers with w_ack or w_err (sampled on clk);
  // w_err wins when both arrive together. Core side: ack is a one-cycle pulse
  // qualified by err; the core holds its request until it sees ack.

  localparam int RW    = $clog2(REGS_PER_THREAD);
  localparam int IDX_W = reg_idx_w(THREADS, REGS_PER_THREAD);

  state_t              r_state;
  logic                r_ack;
  logic                r_err;
  logic                r_busy;
  logic                r_bus_req;
  logic                r_bus_write;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [DATA_W-1:0]   r_bus_rdata;
  logic                r_sel_rf;

  logic                w_window;
  logic                w_start;
  logic                w_rf_we;
  logic                w_rf_re;
  logic [IDX_W-1:0]    w_rf_idx;
  logic [DATA_W-1:0]   w_rf_rdata;
  logic                w_tmo;

  assign w_window = (addr[ADDR_W-1 -: 4] == REG_WINDOW_TAG);
  assign w_start  = (r_state == IDLE) && f_enable;
  assign w_rf_we  = w_start && w_window && write_mode;
  assign w_rf_re  = w_start && w_window && !write_mode;
  assign w_rf_idx = {thread, addr[RW-1:0]};

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || r_state != BUS) r_tmo_cnt <= '0;
    else                          r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // Fires on the edge where the count would reach TIMEOUT_CYCLES.
  assign w_tmo = (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo = 1'b0;
`endif

  mem_access_regfile #(
    .DATA_W          (DATA_W),
    .THREADS         (THREADS),
    .REGS_PER_THREAD (REGS_PER_THREAD)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_rf_we),
    .i_re    (w_rf_re),
    .i_idx   (w_rf_idx),
    .i_wdata (data_i),
    .o_rdata (w_rf_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_rdata <= '0;
      r_sel_rf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (f_enable) begin
            r_busy <= 1'b1;
            if (w_window) begin
              r_ack   <= 1'b1;
              r_err   <= 1'b0;
              r_state <= DONE;
              if (!write_mode) r_sel_rf <= 1'b1;
            end else begin
              r_bus_addr  <= addr;
              r_bus_wdata <= data_i;
              r_bus_write <= write_mode;
              r_bus_req   <= 1'b1;
              r_state     <= BUS;
            end
          end
        end
        BUS: begin
          if (w_err) begin
            r_bus_req <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= DONE;
          end else if (w_ack) begin
            r_bus_req <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= 1'b0;
            r_state   <= DONE;
            if (!r_bus_write) begin
              r_bus_rdata <= w_data_i;
              r_sel_rf    <= 1'b0;
            end
          end else if (w_tmo) begin
            r_bus_req <= 1'b0;
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // data_o tracks whichever source completed the most recent load.
  assign data_o   = r_sel_rf ? w_rf_rdata : r_bus_rdata;
  assign ack      = r_ack;
  assign err      = r_err;
  assign busy     = r_busy;
  assign w_addr   = r_bus_addr;
  assign w_data_o = r_bus_wdata;
  assign w_write  = r_bus_write;
  assign w_req    = r_bus_req;
  assign o_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: drivers push expected {err,data} responses,
// a negedge monitor pops and compares on every ack. Honours MEM_ACCESS_TIMEOUT_EN.
module tb_mem_access_unit;
  import cpu_mem_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TH  = 4;
  localparam int RPT = 8;
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_enable = 1'b0;
  logic          write_mode = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_i = '0;
  logic [1:0]    thread = '0;
  logic [DW-1:0] data_o;
  logic          ack, err, busy;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data_o;
  logic          w_write, w_req;
  logic [DW-1:0] w_data_i = '0;
  logic          w_ack = 1'b0;
  logic          w_err = 1'b0;
  state_t        state;

  int n_vec  = 0;
  int n_miss = 0;
  logic [DW:0] exp_q[$];

  mem_access_unit #(
    .DATA_W(DW), .ADDR_W(AW), .THREADS(TH), .REGS_PER_THREAD(RPT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .f_enable(f_enable), .write_mode(write_mode),
    .addr(addr), .data_i(data_i), .thread(thread), .data_o(data_o),
    .ack(ack), .err(err), .busy(busy), .w_addr(w_addr), .w_data_o(w_data_o),
    .w_write(w_write), .w_req(w_req), .w_data_i(w_data_i), .w_ack(w_ack),
    .w_err(w_err), .o_state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  logic [DW:0] mon_e;
  always @(negedge clk) begin
    if (rst_n && ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ack: got ack=1 err=%b data=%h, expected no ack", err, data_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_err", {31'd0, err}, {31'd0, mon_e[DW]});
        check("resp_data", data_o, mon_e[DW-1:0]);
      end
    end
  end

  // drivers
  task automatic reg_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [1:0] th, input logic [DW-1:0] exp_data);
    @(posedge clk); #1;
    write_mode = we; addr = a; data_i = d; thread = th; f_enable = 1'b1;
    exp_q.push_back({1'b0, exp_data});
    @(posedge clk); #1;
    f_enable = 1'b0;
    @(negedge clk);
    check("reg_ack_latency", {31'd0, ack}, 32'd1);
    check("reg_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("reg_idle", {31'd0, busy}, 32'd0);
  endtask

  // rsp: 0 = w_ack, 1 = w_err, 2 = both together
  task automatic bus_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int delay, input int rsp, input logic [DW-1:0] rdata,
                            input logic [DW-1:0] exp_data);
    logic held;
    @(posedge clk); #1;
    write_mode = we; addr = a; data_i = d; thread = 2'd0; f_enable = 1'b1;
    exp_q.push_back({(rsp != 0), exp_data});
    @(posedge clk); #1;
    @(negedge clk);
    check("bus_req", {31'd0, w_req}, 32'd1);
    check("bus_addr", w_addr, a);
    check("bus_write", {31'd0, w_write}, {31'd0, we});
    if (we) check("bus_wdata", w_data_o, d);
    held = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      if (w_req !== 1'b1 || w_addr !== a) held = 1'b0;
    end
    if (delay > 0) check("bus_req_held", {31'd0, held}, 32'd1);
    w_data_i = rdata;
    w_ack = (rsp != 1);
    w_err = (rsp != 0);
    @(posedge clk); #1;
    w_ack = 1'b0; w_err = 1'b0; f_enable = 1'b0;
    @(negedge clk);
    check("bus_ack_latency", {31'd0, ack}, 32'd1);
    check("bus_req_drop", {31'd0, w_req}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bus_idle", {31'd0, busy}, 32'd0);
  endtask

  // stimulus
  int req_cnt;
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req", {31'd0, w_req}, 32'd0);
    check("rst_write", {31'd0, w_write}, 32'd0);
    check("rst_data_o", data_o, 32'h0);
    check("rst_w_addr", w_addr, 32'h0);
    check("rst_w_data_o", w_data_o, 32'h0);
    check("rst_state", {30'd0, state}, {30'd0, IDLE});

    reg_access(1'b1, 32'hF000_0003, 32'hDEAD_BEEF, 2'd2, 32'h0000_0000);
    reg_access(1'b0, 32'hF000_0003, 32'h0,         2'd2, 32'hDEAD_BEEF);
    reg_access(1'b0, 32'hF000_0003, 32'h0,         2'd1, 32'h0000_0000);
    reg_access(1'b1, 32'hF000_0013, 32'h1111_1111, 2'd3, 32'h0000_0000);
    reg_access(1'b0, 32'hF000_0003, 32'h0,         2'd2, 32'hDEAD_BEEF);

    bus_access(1'b0, 32'h0000_1000, 32'h0,         3, 0, 32'h1234_5678, 32'h1234_5678);
    bus_access(1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 1, 0, 32'h0,         32'h1234_5678);
    bus_access(1'b0, 32'h0000_3000, 32'h0,         2, 2, 32'hFFFF_0000, 32'h1234_5678);
    bus_access(1'b0, 32'hEFFF_FFFF, 32'h0,         0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    bus_access(1'b0, 32'h0000_6000, 32'h0,         1, 1, 32'h0BAD_BEEF, 32'hCAFE_F00D);

    // silent slave
    @(posedge clk); #1;
    write_mode = 1'b0; addr = 32'h0000_4000; f_enable = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
    exp_q.push_back({1'b1, 32'hCAFE_F00D});
`endif
    @(posedge clk); #1;
    req_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (w_req !== 1'b1) break;
      req_cnt++;
    end
    f_enable = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("timeout_req_cycles", req_cnt, 32'd4);
    check("timeout_ack", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    write_mode = 1'b0; addr = 32'h0000_5000; f_enable = 1'b1;
    @(posedge clk); #1;
    f_enable = 1'b0;
`else
    check("no_timeout_req_held", req_cnt, 32'd100);
`endif

    // reset while in BUS
    @(posedge clk); #1;
    check("pre_reset_req", {31'd0, w_req}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_req", {31'd0, w_req}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ack", {31'd0, ack}, 32'd0);
    check("midrst_data_o", data_o, 32'h0);
    repeat (3) @(negedge clk);
    reg_access(1'b0, 32'hF000_0003, 32'h0, 2'd2, 32'h0000_0000);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
